// File: rtl/debug_display_pkg.sv
// Shared constants and the hex-to-segment decode used by the debug hex display.
package debug_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
        return ~SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw active-low button, debounces its level and emits a
// one-cycle pulse on each accepted press (debounced 1->0 transition).
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            // The counter tracks consecutive samples that disagree with the accepted level
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_reg   <= '0;
                level_reg <= sync2_reg;
                press_reg <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/debug_hex_display.sv
// N-channel probe selector driving a bank of active-low 7-segment hex digits,
// with manual/auto channel stepping, freeze-on-hold and optional zero blanking.
module debug_hex_display
    import debug_display_pkg::*;
#(
    parameter  int unsigned NUM_CHANNELS    = 4,
    parameter  int unsigned WIDTH           = 16,
    parameter  int unsigned DEBOUNCE_CYCLES = 500000,
    parameter  int unsigned DWELL_CYCLES    = 50000000,
    parameter  bit          BLANK_LZ        = 1'b0,
    localparam int unsigned NUM_DIGITS      = WIDTH / 4,
    localparam int unsigned CH_W            = $clog2(NUM_CHANNELS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CHANNELS*WIDTH-1:0] probe_bus,
    input  logic                          btn_next,
    input  logic                          btn_hold,
    input  logic                          auto_mode,
    output logic [NUM_DIGITS*7-1:0]       hex_n,
    output logic [CH_W-1:0]               channel_sel,
    output logic                          held
);

    localparam int unsigned DW_W = $clog2(DWELL_CYCLES);

    logic [WIDTH-1:0]        probe_words [NUM_CHANNELS];
    logic                    next_press;
    logic                    hold_press;
    logic                    dwell_expire;
    logic                    advance;
    logic [CH_W-1:0]         ch_reg,    ch_next;
    logic                    held_reg,  held_next;
    logic [WIDTH-1:0]        snap_reg,  snap_next;
    logic [DW_W-1:0]         dwell_reg, dwell_next;
    logic [NUM_DIGITS*7-1:0] hex_reg,   hex_next;
    logic [WIDTH-1:0]        disp_word;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_probe
            assign probe_words[gi] = probe_bus[gi*WIDTH +: WIDTH];
        end
    endgenerate

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_next),
        .press   (next_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold_db (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_hold),
        .press   (hold_press)
    );

    always_comb begin
        dwell_expire = auto_mode && (dwell_reg == DW_W'(DWELL_CYCLES - 1));
        // A manual press coinciding with expiry still yields a single step
        advance      = next_press || dwell_expire;

        dwell_next = dwell_reg + 1'b1;
        if (!auto_mode || advance) begin
            dwell_next = '0;
        end

        ch_next = ch_reg;
        if (advance) begin
            ch_next = (ch_reg == CH_W'(NUM_CHANNELS - 1)) ? '0 : ch_reg + 1'b1;
        end

        held_next = held_reg ^ hold_press;

        // Capture on entering hold, and follow the channel if it steps while frozen
        snap_next = snap_reg;
        if (held_next && (advance || !held_reg)) begin
            snap_next = probe_words[ch_next];
        end

        disp_word = held_reg ? snap_reg : probe_words[ch_reg];
    end

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            logic       shown;
            assign nib = disp_word[gi*4 +: 4];
            if (gi == 0) begin : g_lsd
                assign shown = 1'b1;
            end else begin : g_upper
                assign shown = |disp_word[WIDTH-1:gi*4];
            end
            if (BLANK_LZ) begin : g_blank
                assign hex_next[gi*7 +: 7] = shown ? hex_to_seg_n(nib) : SEG_BLANK;
            end else begin : g_plain
                assign hex_next[gi*7 +: 7] = hex_to_seg_n(nib);
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ch_reg    <= '0;
            held_reg  <= 1'b0;
            snap_reg  <= '0;
            dwell_reg <= '0;
            hex_reg   <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            ch_reg    <= ch_next;
            held_reg  <= held_next;
            snap_reg  <= snap_next;
            dwell_reg <= dwell_next;
            hex_reg   <= hex_next;
        end
    end

    assign hex_n       = hex_reg;
    assign channel_sel = ch_reg;
    assign held        = held_reg;

endmodule

// File: tb/tb_debug_hex_display.sv
// Directed/random bench for debug_hex_display: two instances (blanking off/on)
// share stimulus and are compared against a behavioural model.
module tb_debug_hex_display;

    localparam int W  = 16;
    localparam int NC = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [NC*W-1:0] probe_bus;
    logic          btn_next;
    logic          btn_hold;
    logic          auto_mode;
    logic [27:0]   hex0, hex1;
    logic [1:0]    ch0, ch1;
    logic          held0, held1;

    int n_checks = 0;
    int n_pass   = 0;

    int         exp_ch   = 0;
    bit         exp_held = 0;
    logic [15:0] exp_snap = '0;

    logic [6:0] seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clock = ~clock;

    debug_hex_display #(.NUM_CHANNELS(NC), .WIDTH(W), .DEBOUNCE_CYCLES(8),
                        .DWELL_CYCLES(10), .BLANK_LZ(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .probe_bus(probe_bus), .btn_next(btn_next),
        .btn_hold(btn_hold), .auto_mode(auto_mode), .hex_n(hex0),
        .channel_sel(ch0), .held(held0));

    debug_hex_display #(.NUM_CHANNELS(NC), .WIDTH(W), .DEBOUNCE_CYCLES(8),
                        .DWELL_CYCLES(10), .BLANK_LZ(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .probe_bus(probe_bus), .btn_next(btn_next),
        .btn_hold(btn_hold), .auto_mode(auto_mode), .hex_n(hex1),
        .channel_sel(ch1), .held(held1));

    // Reference decode: digit d is hex value (w / 16^d) mod 16; blanked when
    // everything from digit d upward is zero (never for digit 0).
    function automatic logic [27:0] model_hex(input logic [15:0] w, input bit blank);
        logic [27:0] r;
        for (int d = 0; d < 4; d++) begin
            int unsigned upper;
            upper = int'(w) / (1 << (4 * d));
            r[d*7 +: 7] = ~seg_tab[upper % 16];
            if (blank && d > 0 && upper == 0) r[d*7 +: 7] = 7'h7F;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom());
        return w >> $urandom_range(0, 16);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_word(input int k, input logic [15:0] w);
        probe_bus[k*W +: W] = w;
    endtask

    task automatic check_disp(input string tag);
        logic [15:0] w;
        w = exp_held ? exp_snap : probe_bus[exp_ch*W +: W];
        chk({tag, "_hex_lz0"}, 32'(hex0), 32'(model_hex(w, 1'b0)));
        chk({tag, "_hex_lz1"}, 32'(hex1), 32'(model_hex(w, 1'b1)));
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ch"}, 32'(ch0), 32'(exp_ch));
        chk({tag, "_ch_b"}, 32'(ch1), 32'(exp_ch));
        chk({tag, "_held"}, 32'(held0), 32'(exp_held));
        chk({tag, "_held_b"}, 32'(held1), 32'(exp_held));
    endtask

    task automatic press(input bit do_next, input bit do_hold, input int low_cycles,
                         output int changes);
        logic [1:0] prev;
        changes = 0;
        prev    = ch0;
        if (do_next) btn_next = 1'b0;
        if (do_hold) btn_hold = 1'b0;
        repeat (low_cycles) begin
            tick();
            if (ch0 != prev) changes++;
            prev = ch0;
        end
        btn_next = 1'b1;
        btn_hold = 1'b1;
        repeat (20) begin
            tick();
            if (ch0 != prev) changes++;
            prev = ch0;
        end
    endtask

    task automatic wait_change(output int n);
        logic [1:0] prev;
        prev = ch0;
        n    = 0;
        do begin
            tick();
            n++;
        end while (ch0 == prev && n < 40);
        chk("wait_change_timeout", 32'(ch0 != prev), 32'd1);
    endtask

    initial begin
        int c;
        logic [15:0] w;

        reset     = 1'b0;
        btn_next  = 1'b0;
        btn_hold  = 1'b0;
        auto_mode = 1'b0;
        probe_bus = 48'({$urandom(), $urandom()});
        repeat (5) tick();
        chk("reset_hex0", 32'(hex0), 32'h0FFF_FFFF);
        chk("reset_hex1", 32'(hex1), 32'h0FFF_FFFF);
        check_state("reset");

        btn_next = 1'b1;
        btn_hold = 1'b1;
        tick();
        reset = 1'b1;
        set_word(0, 16'h1234);
        repeat (3) tick();
        chk("digits_1234", 32'(hex0), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
        check_disp("ch0_1234");

        press(1'b1, 1'b0, 5, c);
        chk("short_press_changes", 32'(c), 32'd0);
        check_state("short_press");

        for (int i = 0; i < 3; i++) begin
            press(1'b1, 1'b0, 20, c);
            exp_ch = (exp_ch + 1) % NC;
            chk("press_once", 32'(c), 32'd1);
            check_state("press_step");
            check_disp("press_step");
        end

        for (int i = 0; i < 12; i++) begin
            set_word(0, rand_word());
            set_word(1, rand_word());
            set_word(2, rand_word());
            tick();
            check_disp("rand_live");
        end

        set_word(0, 16'h00AB);
        tick();
        press(1'b0, 1'b1, 20, c);
        exp_held = 1;
        exp_snap = 16'h00AB;
        chk("hold_no_step", 32'(c), 32'd0);
        set_word(0, 16'hFFFF);
        repeat (2) tick();
        chk("held_00AB_lz1", 32'(hex1), 32'({7'h7F, 7'h7F, 7'h08, 7'h03}));
        check_disp("held_00AB");
        check_state("held_00AB");

        w = rand_word();
        set_word(1, w);
        press(1'b1, 1'b0, 20, c);
        exp_ch   = 1;
        exp_snap = w;
        set_word(1, ~w);
        repeat (2) tick();
        check_disp("held_step");
        check_state("held_step");

        press(1'b0, 1'b1, 20, c);
        exp_held = 0;
        check_disp("unhold");
        check_state("unhold");

        press(1'b1, 1'b0, 20, c);
        press(1'b1, 1'b0, 20, c);
        exp_ch = 0;
        check_state("back_to_0");
        w = rand_word();
        set_word(1, w);
        press(1'b1, 1'b1, 20, c);
        exp_ch   = 1;
        exp_held = 1;
        exp_snap = w;
        set_word(1, rand_word());
        repeat (2) tick();
        chk("same_cycle_changes", 32'(c), 32'd1);
        check_state("same_cycle");
        check_disp("same_cycle");
        press(1'b0, 1'b1, 20, c);
        exp_held = 0;

        auto_mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_change(c);
            exp_ch = (exp_ch + 1) % NC;
            chk("auto_interval", 32'(c), 32'd10);
            chk("auto_ch", 32'(ch0), 32'(exp_ch));
        end
        repeat (4) tick();
        btn_next = 1'b0;
        wait_change(c);
        exp_ch = (exp_ch + 1) % NC;
        chk("auto_before_manual", 32'(c), 32'd6);
        wait_change(c);
        exp_ch = (exp_ch + 1) % NC;
        btn_next = 1'b1;
        chk("manual_at_dwell5", 32'(c), 32'd5);
        chk("manual_ch", 32'(ch0), 32'(exp_ch));
        wait_change(c);
        exp_ch = (exp_ch + 1) % NC;
        chk("auto_after_manual", 32'(c), 32'd10);
        check_state("auto_after_manual");

        auto_mode = 1'b0;
        repeat (25) tick();
        check_state("auto_off_stays");
        auto_mode = 1'b1;
        repeat (5) tick();
        auto_mode = 1'b0;
        repeat (3) tick();
        auto_mode = 1'b1;
        wait_change(c);
        exp_ch = (exp_ch + 1) % NC;
        chk("dwell_cleared_interval", 32'(c), 32'd10);
        auto_mode = 1'b0;
        tick();

        press(1'b0, 1'b1, 20, c);
        exp_held = 1;
        btn_next = 1'b0;
        repeat (6) tick();
        reset = 1'b0;
        #2;
        exp_ch   = 0;
        exp_held = 0;
        chk("midreset_hex0", 32'(hex0), 32'h0FFF_FFFF);
        chk("midreset_hex1", 32'(hex1), 32'h0FFF_FFFF);
        check_state("midreset");
        tick();
        btn_next = 1'b1;
        reset    = 1'b1;
        repeat (30) tick();
        check_state("after_reset");
        check_disp("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
